// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Issues instruction reads to a memory bus and hands the returned words to
// decode in program order. At most DEPTH instructions are in flight at once;
// that count covers both reads still waiting on the bus and words already
// buffered for decode. Redirects flush everything in flight, and returns that
// belong to reads issued before the redirect are dropped as they arrive.
//
// Optional build macro:
//   INSTRUCTION_FETCH_MISALIGN_CHECK_EN - adds misalign_fault. While the PC
//   is not word aligned no request is issued, and the fault stays set until
//   a redirect.
//
// Parameters:
//   RESET_PC - value shown on instr_pc whenever no instruction is held
//   DEPTH    - maximum instructions in flight (outstanding + buffered)
//
// Ports:
//   clk                 in   rising-edge clock
//   reset_n             in   asynchronous reset, active low
//   pc_value            in   current PC register value
//   pc_write_data       out  next PC value
//   pc_write_enable     out  PC register write strobe
//   redirect_valid      in   branch/jump redirect request
//   redirect_pc         in   redirect target address
//   bus_read_req        out  instruction read request
//   bus_addr            out  word-aligned read address
//   bus_ready           in   bus accepts the request this cycle
//   bus_read_data       in   returned instruction word
//   bus_read_data_valid in   return strobe (in order, latency >= 1)
//   instr_valid         out  instruction available to decode
//   instr               out  instruction word
//   instr_pc            out  address of instr
//   instr_ready         in   decode consumes the instruction
//   misalign_fault      out  (macro only) PC misaligned, fetch stalled
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_value,
    output logic [31:0] pc_write_data,
    output logic        pc_write_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        bus_read_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_data_valid,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_fault
`endif
);

    // Counter width holds 0..DEPTH; pointer width indexes 0..DEPTH-1.
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Circular pointer advance that also works for non-power-of-two DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = PW'(0);
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    // Bus reads not yet returned, including ones that will be dropped.
    logic [CW-1:0] out_cnt_q,  out_cnt_d;
    // Returns still to be thrown away after a redirect.
    logic [CW-1:0] disc_cnt_q, disc_cnt_d;

    // Tag queue: PCs of live (non-discarded) outstanding reads, oldest first.
    logic [31:0]   tag_mem_q [DEPTH];
    logic [31:0]   tag_mem_d [DEPTH];
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;

    // Instruction buffer: {pc, word} pairs waiting for decode.
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [PW-1:0] fifo_rd_q,  fifo_rd_d;
    logic [PW-1:0] fifo_wr_q,  fifo_wr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
`endif

    logic [CW:0] credit_used_s;
    logic        fault_s;
    logic        req_s;
    logic        accept_s;
    logic        ret_s;
    logic        keep_s;
    logic        pop_s;

    // Handshake decode: credit check, request acceptance, return and pop.
    always_comb begin
        credit_used_s = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
        fault_s       = fault_q || (pc_value[1:0] != 2'b00);
`else
        fault_s       = 1'b0;
`endif
        // Redirect wins over a new request in the same cycle.
        req_s    = reset_n && (credit_used_s < DEPTH_C) && !redirect_valid && !fault_s;
        accept_s = req_s && bus_ready;
        // A strobe with nothing outstanding is spurious and is ignored.
        ret_s    = bus_read_data_valid && (out_cnt_q != CW'(0));
        // A return is kept only if no redirect is flushing it now or earlier.
        keep_s   = ret_s && !redirect_valid && (disc_cnt_q == CW'(0));
        pop_s    = (fifo_cnt_q != CW'(0)) && instr_ready && !redirect_valid;
    end

    // Next-state for counters, tag queue and instruction buffer.
    always_comb begin
        out_cnt_d   = out_cnt_q + CW'(accept_s) - CW'(ret_s);
        disc_cnt_d  = disc_cnt_q;
        tag_mem_d   = tag_mem_q;
        tag_rd_d    = tag_rd_q;
        tag_wr_d    = tag_wr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_data_d = fifo_data_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_cnt_d  = fifo_cnt_q;
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
        fault_d     = fault_q;
`endif

        if (redirect_valid) begin
            // Every read still outstanding after this cycle is now stale.
            disc_cnt_d = out_cnt_q - CW'(ret_s);
            tag_rd_d   = PW'(0);
            tag_wr_d   = PW'(0);
            fifo_rd_d  = PW'(0);
            fifo_wr_d  = PW'(0);
            fifo_cnt_d = CW'(0);
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
            fault_d    = 1'b0;
`endif
        end else begin
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
            fault_d = fault_s;
`endif
            if (ret_s && (disc_cnt_q != CW'(0))) begin
                disc_cnt_d = disc_cnt_q - CW'(1);
            end else begin
                disc_cnt_d = disc_cnt_q;
            end

            if (accept_s) begin
                tag_mem_d[tag_wr_q] = pc_value;
                tag_wr_d            = ptr_inc(tag_wr_q);
            end else begin
                tag_wr_d = tag_wr_q;
            end

            if (keep_s) begin
                // Returns are in order, so the tag head names this word.
                fifo_pc_d[fifo_wr_q]   = tag_mem_q[tag_rd_q];
                fifo_data_d[fifo_wr_q] = bus_read_data;
                fifo_wr_d              = ptr_inc(fifo_wr_q);
                tag_rd_d               = ptr_inc(tag_rd_q);
            end else begin
                fifo_wr_d = fifo_wr_q;
                tag_rd_d  = tag_rd_q;
            end

            if (pop_s) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end else begin
                fifo_rd_d = fifo_rd_q;
            end

            // Simultaneous push and pop leave occupancy unchanged.
            fifo_cnt_d = fifo_cnt_q + CW'(keep_s) - CW'(pop_s);
        end
    end

    // State registers; reset drops everything in flight immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt_q  <= CW'(0);
            disc_cnt_q <= CW'(0);
            tag_rd_q   <= PW'(0);
            tag_wr_q   <= PW'(0);
            fifo_rd_q  <= PW'(0);
            fifo_wr_q  <= PW'(0);
            fifo_cnt_q <= CW'(0);
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_mem_q[i]   <= 32'h0000_0000;
                fifo_pc_q[i]   <= 32'h0000_0000;
                fifo_data_q[i] <= 32'h0000_0000;
            end
        end else begin
            out_cnt_q   <= out_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            tag_rd_q    <= tag_rd_d;
            tag_wr_q    <= tag_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_cnt_q  <= fifo_cnt_d;
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
            fault_q     <= fault_d;
`endif
            tag_mem_q   <= tag_mem_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    // PC update and bus address; forced to zero while reset is held.
    always_comb begin
        pc_write_enable = 1'b0;
        pc_write_data   = 32'h0000_0000;
        bus_addr        = 32'h0000_0000;
        if (reset_n) begin
            bus_addr = {pc_value[31:2], 2'b00};
            if (redirect_valid) begin
                pc_write_enable = 1'b1;
                pc_write_data   = redirect_pc;
            end else if (accept_s) begin
                pc_write_enable = 1'b1;
                pc_write_data   = pc_value + 32'd4;
            end else begin
                pc_write_enable = 1'b0;
                pc_write_data   = 32'h0000_0000;
            end
        end else begin
            pc_write_enable = 1'b0;
            pc_write_data   = 32'h0000_0000;
            bus_addr        = 32'h0000_0000;
        end
    end

    // Decode-side view of the buffer head.
    always_comb begin
        instr_valid = (fifo_cnt_q != CW'(0));
        instr       = 32'h0000_0000;
        instr_pc    = RESET_PC;
        if (instr_valid) begin
            instr    = fifo_data_q[fifo_rd_q];
            instr_pc = fifo_pc_q[fifo_rd_q];
        end else begin
            instr    = 32'h0000_0000;
            instr_pc = RESET_PC;
        end
    end

    assign bus_read_req = req_s;

`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
    assign misalign_fault = reset_n && fault_s;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h1000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_value;
    logic [31:0] pc_write_data;
    logic        pc_write_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        bus_read_req;
    logic [31:0] bus_addr;
    logic        bus_ready;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .pc_value            (pc_value),
        .pc_write_data       (pc_write_data),
        .pc_write_enable     (pc_write_enable),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .bus_read_req        (bus_read_req),
        .bus_addr            (bus_addr),
        .bus_ready           (bus_ready),
        .bus_read_data       (bus_read_data),
        .bus_read_data_valid (bus_read_data_valid),
        .instr_valid         (instr_valid),
        .instr               (instr),
        .instr_pc            (instr_pc),
        .instr_ready         (instr_ready)
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault      (misalign_fault)
`endif
    );

    // Reference model: reads in flight (stale ones marked), decode buffer,
    // and a bus model holding accepted addresses with their due cycle.
    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
    typedef struct { logic [31:0] addr; int due; } bus_t;

    flight_t     inflight[$];
    entry_t      fifo_m[$];
    bus_t        bus_q[$];
    logic [31:0] popped_pc[$];

    int n_pass, n_total, cyc;
    bit rnd_mode, bus_hold, m_fault;
    int lat_min, lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: check DUT against the model at negedge, advance model,
    // then drive environment inputs just after the rising edge.
    task automatic step();
        bit          e_req, e_acc, e_we, e_val, f_now;
        logic [31:0] e_wd, next_pc, r;
        flight_t     f;
        entry_t      en;
        bus_t        b;
        @(negedge clk);
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
        f_now = m_fault || (pc_value[1:0] != 2'b00);
`else
        f_now = 1'b0;
`endif
        e_req = ((inflight.size() + fifo_m.size()) < DEPTH) && !redirect_valid && !f_now;
        e_acc = e_req && bus_ready;
        e_we  = redirect_valid || e_acc;
        e_wd  = redirect_valid ? redirect_pc : pc_value + 32'd4;
        e_val = (fifo_m.size() > 0);

        n_total++;
        if (bus_read_req !== e_req) $display("FAIL bus_read_req cyc=%0d got=%b exp=%b", cyc, bus_read_req, e_req);
        else n_pass++;
        n_total++;
        if (pc_write_enable !== e_we) $display("FAIL pc_write_enable cyc=%0d got=%b exp=%b", cyc, pc_write_enable, e_we);
        else n_pass++;
        if (e_we) begin
            n_total++;
            if (pc_write_data !== e_wd) $display("FAIL pc_write_data cyc=%0d got=%h exp=%h", cyc, pc_write_data, e_wd);
            else n_pass++;
        end
        n_total++;
        if (bus_addr !== {pc_value[31:2], 2'b00}) $display("FAIL bus_addr cyc=%0d got=%h exp=%h", cyc, bus_addr, {pc_value[31:2], 2'b00});
        else n_pass++;
        n_total++;
        if (instr_valid !== e_val) $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, e_val);
        else n_pass++;
        if (e_val) begin
            n_total++;
            if (instr !== fifo_m[0].data) $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr, fifo_m[0].data);
            else n_pass++;
            n_total++;
            if (instr_pc !== fifo_m[0].pc) $display("FAIL instr_pc cyc=%0d got=%h exp=%h", cyc, instr_pc, fifo_m[0].pc);
            else n_pass++;
        end else begin
            n_total++;
            if (instr_pc !== RESET_PC) $display("FAIL instr_pc_idle cyc=%0d got=%h exp=%h", cyc, instr_pc, RESET_PC);
            else n_pass++;
        end
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
        n_total++;
        if (misalign_fault !== f_now) $display("FAIL misalign_fault cyc=%0d got=%b exp=%b", cyc, misalign_fault, f_now);
        else n_pass++;
`endif

        // Model advance: pop, return, redirect flush, new request.
        if (e_val && instr_ready && !redirect_valid) begin
            popped_pc.push_back(fifo_m[0].pc);
            void'(fifo_m.pop_front());
        end
        if (bus_read_data_valid && inflight.size() > 0) begin
            f = inflight.pop_front();
            if (!f.stale && !redirect_valid) begin
                en.pc   = f.pc;
                en.data = bus_read_data;
                fifo_m.push_back(en);
            end
        end
        if (redirect_valid) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
        end
        if (e_acc) begin
            f.pc    = pc_value;
            f.stale = 1'b0;
            inflight.push_back(f);
            b.addr = {pc_value[31:2], 2'b00};
            b.due  = cyc + int'($urandom_range(lat_max, lat_min));
            bus_q.push_back(b);
        end
        m_fault = redirect_valid ? 1'b0 : f_now;
        next_pc = e_we ? e_wd : pc_value;

        @(posedge clk);
        #1;
        cyc++;
        pc_value = next_pc;
        if (!bus_hold && bus_q.size() > 0 && bus_q[0].due <= cyc && (!rnd_mode || $urandom_range(3, 0) != 0)) begin
            bus_read_data_valid = 1'b1;
            bus_read_data       = mem_word(bus_q[0].addr);
            void'(bus_q.pop_front());
        end else begin
            bus_read_data_valid = 1'b0;
            bus_read_data       = $urandom;
        end
        if (rnd_mode) begin
            bus_ready      = ($urandom_range(1, 0) == 1);
            instr_ready    = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            r              = $urandom;
            redirect_pc    = {r[31:2], 2'b00};
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rnd_mode = 1'b0; redirect_valid = 1'b0; bus_ready = 1'b0; instr_ready = 1'b1; bus_hold = 1'b0;
        while ((inflight.size() + fifo_m.size()) != 0 && n < 60) begin
            step();
            n++;
        end
        n_total++;
        if ((inflight.size() + fifo_m.size()) != 0) $display("FAIL drain_timeout cyc=%0d left=%0d exp=0", cyc, inflight.size() + fifo_m.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pc_value = 32'h2345_6788; redirect_valid = 1'b1; redirect_pc = 32'h5555_5554;
        bus_ready = 1'b1; bus_read_data_valid = 1'b1; bus_read_data = 32'hFFFF_FFFF; instr_ready = 1'b1;
        #3;
        n_total++; if (bus_read_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bus_read_req); else n_pass++;
        n_total++; if (pc_write_enable !== 1'b0) $display("FAIL rst_we got=%b exp=0", pc_write_enable); else n_pass++;
        n_total++; if (pc_write_data !== 32'h0) $display("FAIL rst_wd got=%h exp=0", pc_write_data); else n_pass++;
        n_total++; if (bus_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", bus_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr); else n_pass++;
        n_total++; if (instr_pc !== RESET_PC) $display("FAIL rst_instr_pc got=%h exp=%h", instr_pc, RESET_PC); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid_clk got=%b exp=0", instr_valid); else n_pass++;
        pc_value = RESET_PC; redirect_valid = 1'b0; bus_read_data_valid = 1'b0; bus_ready = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1; bus_ready = 1'b1; instr_ready = 1'b1;
        popped_pc.delete();
        repeat (8) step();
        n_total++;
        if (popped_pc.size() < 3) $display("FAIL seq_count got=%0d exp>=3", popped_pc.size());
        else begin
            n_pass++;
            n_total++; if (popped_pc[0] !== 32'h1000_0000) $display("FAIL seq_pc0 got=%h exp=10000000", popped_pc[0]); else n_pass++;
            n_total++; if (popped_pc[1] !== 32'h1000_0004) $display("FAIL seq_pc1 got=%h exp=10000004", popped_pc[1]); else n_pass++;
            n_total++; if (popped_pc[2] !== 32'h1000_0008) $display("FAIL seq_pc2 got=%h exp=10000008", popped_pc[2]); else n_pass++;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] exp_next;
        lat_min = 1; lat_max = 1; bus_ready = 1'b1; instr_ready = 1'b0;
        n = 0;
        while (fifo_m.size() < 2 && n < 20) begin step(); n++; end
        n_total++;
        if (fifo_m.size() < 2) $display("FAIL bp_fill_timeout got=%0d exp=2", fifo_m.size());
        else begin
            n_pass++;
            n_total++; if (bus_read_req !== 1'b0) $display("FAIL bp_req_full got=%b exp=0", bus_read_req); else n_pass++;
            exp_next = fifo_m[1].pc;
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            n_total++; if (instr_pc !== exp_next) $display("FAIL bp_one_pop got=%h exp=%h", instr_pc, exp_next); else n_pass++;
            n_total++; if (bus_read_req !== 1'b1) $display("FAIL bp_new_req got=%b exp=1", bus_read_req); else n_pass++;
            step();
            n_total++; if (bus_read_req !== 1'b0) $display("FAIL bp_req_again got=%b exp=0", bus_read_req); else n_pass++;
        end
        drain();
    endtask

    task automatic test_redirect();
        int n;
        lat_min = 1; lat_max = 1; bus_hold = 1'b1; bus_ready = 1'b1; instr_ready = 1'b1;
        step(); step();
        n_total++; if (bus_read_req !== 1'b0) $display("FAIL rd_two_out got=%b exp=0", bus_read_req); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h2000_0000;
        #1;
        n_total++; if (pc_write_data !== 32'h2000_0000) $display("FAIL rd_wd got=%h exp=20000000", pc_write_data); else n_pass++;
        n_total++; if (pc_write_enable !== 1'b1) $display("FAIL rd_we got=%b exp=1", pc_write_enable); else n_pass++;
        popped_pc.delete();
        step();
        redirect_valid = 1'b0; bus_hold = 1'b0;
        n = 0;
        while (popped_pc.size() == 0 && n < 20) begin step(); n++; end
        n_total++;
        if (popped_pc.size() == 0) $display("FAIL rd_timeout got=0 exp=1");
        else if (popped_pc[0] !== 32'h2000_0000) $display("FAIL rd_first_pc got=%h exp=20000000", popped_pc[0]);
        else n_pass++;
        drain();
    endtask

    task automatic test_wrap();
        pc_value = 32'hFFFF_FFFC; bus_ready = 1'b1; instr_ready = 1'b1; lat_min = 1; lat_max = 2;
        #1;
        n_total++; if (pc_write_data !== 32'h0000_0000) $display("FAIL wrap_wd got=%h exp=00000000", pc_write_data); else n_pass++;
        n_total++; if (pc_write_enable !== 1'b1) $display("FAIL wrap_we got=%b exp=1", pc_write_enable); else n_pass++;
        repeat (4) step();
        drain();
    endtask

    task automatic test_reset_midflight();
        bus_hold = 1'b1; bus_ready = 1'b1; instr_ready = 1'b1; lat_min = 1; lat_max = 1;
        step();
        bus_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (bus_read_req !== 1'b0) $display("FAIL mrst_req got=%b exp=0", bus_read_req); else n_pass++;
        n_total++; if (pc_write_enable !== 1'b0) $display("FAIL mrst_we got=%b exp=0", pc_write_enable); else n_pass++;
        n_total++; if (bus_addr !== 32'h0) $display("FAIL mrst_addr got=%h exp=0", bus_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL mrst_valid got=%b exp=0", instr_valid); else n_pass++;
        n_total++; if (instr_pc !== RESET_PC) $display("FAIL mrst_instr_pc got=%h exp=%h", instr_pc, RESET_PC); else n_pass++;
        inflight.delete(); fifo_m.delete(); bus_q.delete(); m_fault = 1'b0;
        pc_value = RESET_PC;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        bus_hold = 1'b0; bus_ready = 1'b1;
        bus_read_data_valid = 1'b1; bus_read_data = 32'hDEAD_BEEF;
        #1;
        n_total++; if (bus_read_req !== 1'b1) $display("FAIL mrst_resume got=%b exp=1", bus_read_req); else n_pass++;
        repeat (6) step();
        drain();
    endtask

`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        pc_value = 32'h1000_0002; bus_ready = 1'b1; instr_ready = 1'b1;
        #1;
        n_total++; if (bus_read_req !== 1'b0) $display("FAIL mis_req got=%b exp=0", bus_read_req); else n_pass++;
        n_total++; if (misalign_fault !== 1'b1) $display("FAIL mis_fault got=%b exp=1", misalign_fault); else n_pass++;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h1000_0010;
        step();
        redirect_valid = 1'b0;
        n_total++; if (misalign_fault !== 1'b0) $display("FAIL mis_clear got=%b exp=0", misalign_fault); else n_pass++;
        n_total++; if (bus_read_req !== 1'b1) $display("FAIL mis_resume got=%b exp=1", bus_read_req); else n_pass++;
        step();
        drain();
    endtask
`endif

    task automatic test_random();
        lat_min = 1; lat_max = 4; rnd_mode = 1'b1;
        bus_ready = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
        repeat (3000) step();
        drain();
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        rnd_mode = 1'b0; bus_hold = 1'b0; m_fault = 1'b0; lat_min = 1; lat_max = 1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midflight();
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h10000000, PC value reported for instr_pc when no instruction is held.
REQ-002 SHALL have parameter DEPTH, 2, maximum instructions in flight, counting both outstanding bus reads and buffered entries.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous reset, active low.
REQ-005 SHALL have port pc_value  input  32  current PC register value.
REQ-006 SHALL have port pc_write_data  output  32  next PC value.
REQ-007 SHALL have port pc_write_enable  output  1  PC register write strobe.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target address.
REQ-010 SHALL have port bus_read_req  output  1  instruction read request.
REQ-011 SHALL have port bus_addr  output  32  read address, {pc_value[31:2],2'b00}.
REQ-012 SHALL have port bus_ready  input  1  bus accepts the request this cycle.
REQ-013 SHALL have port bus_read_data  input  32  returned instruction word.
REQ-014 SHALL have port bus_read_data_valid  input  1  return strobe; returns are in order with latency of 1 or more cycles.
REQ-015 SHALL have port instr_valid  output  1  instruction available to decode.
REQ-016 SHALL have port instr  output  32  instruction word.
REQ-017 SHALL have port instr_pc  output  32  address of instr.
REQ-018 SHALL have port instr_ready  input  1  decode consumes the instruction.

Function
REQ-019 SHALL assert bus_read_req when (outstanding + buffered) < DEPTH and redirect_valid is 0.
REQ-020 SHALL treat a request as accepted in any cycle where bus_read_req and bus_ready are both 1; on acceptance, pc_write_enable=1, pc_write_data=pc_value+4 (32-bit wrap, so FFFFFFFC becomes 00000000), and pc_value is pushed to a DEPTH-entry tag queue.
REQ-021 SHALL handle redirect_valid=1 in one cycle as follows: pc_write_enable=1, pc_write_data=redirect_pc, no acceptance, instruction buffer and tag queue cleared, discard counter set to the current outstanding count; redirect takes priority over acceptance.
REQ-022 SHALL drop a return that arrives while the discard counter is nonzero and decrement the counter; a return arriving in the same cycle as a redirect SHALL be dropped.
REQ-023 SHALL push each non-discarded return as {tag-queue head, bus_read_data} into a DEPTH-entry FIFO; the instruction SHALL become visible on instr_valid one cycle after its bus_read_data_valid.
REQ-024 SHALL drive instr_valid=1 whenever the FIFO is non-empty, SHALL pop the FIFO on instr_valid && instr_ready, and SHALL keep instr/instr_pc stable until popped.
REQ-025 SHALL support a push and a pop in the same cycle with FIFO occupancy unchanged; the credit rule in REQ-019 SHALL prevent overflow.
REQ-026 SHALL ignore bus_read_data_valid when outstanding=0.
REQ-027 SHALL drive pc_write_enable=0 in any cycle with neither acceptance nor redirect.

Reset
REQ-028 SHALL, while reset_n=0 and independent of clk, drive all outputs to 0 except instr_pc=RESET_PC, and clear the FIFO, tag queue, outstanding count and discard counter.
REQ-029 SHALL resume requesting in the first cycle after reset_n rises, and SHALL never deliver returns of requests issued before reset.

Configuration
REQ-030 SHALL, with INSTRUCTION_FETCH_MISALIGN_CHECK_EN defined, add output misalign_fault (1 bit); when pc_value[1:0]!=0, no request is issued and misalign_fault=1 until a redirect.
REQ-031 SHALL, without INSTRUCTION_FETCH_MISALIGN_CHECK_EN, omit misalign_fault and ignore pc_value[1:0].

Verification
REQ-032 SHALL cover: pc_value=10000000, bus_ready=1, return latency 1, instr_ready=1 -> instrs with pc 10000000, 10000004, 10000008 in order, pc_write_data +4 on each acceptance.
REQ-033 SHALL cover: instr_ready=0 with 2 returns buffered -> bus_read_req=0; instr_ready=1 for one cycle -> exactly one pop and one new request.
REQ-034 SHALL cover: 2 reads outstanding, redirect_pc=20000000 -> both returns dropped, next instr_pc=20000000, pc_write_data=20000000 in the redirect cycle.
REQ-035 SHALL cover: pc_value=FFFFFFFC accepted -> pc_write_data=00000000.
REQ-036 SHALL cover: reset_n asserted mid-flight with 1 outstanding -> outputs at reset values immediately; a late bus_read_data_valid is ignored.
REQ-037 SHALL cover, with the macro defined: pc_value=10000002 -> bus_read_req=0, misalign_fault=1; redirect to 10000010 clears misalign_fault.
